// File: rtl/rotate_seq_ctrl.sv
// rotate_seq_ctrl: sequences one load cycle plus k-1 shift cycles on an external
// rotate-right-by-one register so that rotate-by-k becomes a single start/done handshake.
module rotate_seq_ctrl #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned amt_width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [bit_width-1:0] data_in,
  input  logic [amt_width-1:0] amount,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic                 rot_ld,
  output logic                 rot_sh,
  output logic [bit_width-1:0] rot_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ROT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [bit_width-1:0] data_q, data_d;
  logic [amt_width-1:0] rem_q, rem_d;
  logic                 knz_q, knz_d;

  // State and captured-operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      knz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      knz_q   <= knz_d;
    end
  end

  // Next-state and output decode; the first shift is fused into LOAD, so rem counts the rest
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    knz_d    = knz_q;
    busy     = 1'b1;
    done     = 1'b0;
    rot_ld   = 1'b0;
    rot_sh   = 1'b0;
    rot_data = data_q;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          data_d  = data_in;
          knz_d   = (amount != '0);
          rem_d   = amount - amt_width'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        rot_ld = 1'b1;
        rot_sh = knz_q;
        if (!knz_q || (rem_q == '0)) begin
          state_d = DONE;
        end else begin
          state_d = ROT;
        end
      end
      ROT: begin
        rot_sh = ~hold;
        if (!hold) begin
          rem_d = rem_q - amt_width'(1);
          if (rem_q == amt_width'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Bench for rotate_seq_ctrl: controller driving a behavioural rotate register,
// checked cycle by cycle against a cycle-budget reference model and a result scoreboard.
`timescale 1ns/1ps
module tb_rotate_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic [15:0] data_in;
  logic [3:0]  amount;
  logic        busy, done, rot_ld, rot_sh;
  logic [15:0] rot_data;

  rotate_seq_ctrl #(.bit_width(16), .amt_width(4)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .amount(amount),
    .hold(hold), .busy(busy), .done(done), .rot_ld(rot_ld), .rot_sh(rot_sh),
    .rot_data(rot_data)
  );

  always #5 clk = ~clk;

  // Rotate register driven by the controller, plus a count of shifts issued for the current op
  logic [15:0] reg_q;
  int          shifts;
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q  <= '0;
      shifts <= 0;
    end else if (rot_ld) begin
      reg_q  <= rot_sh ? {rot_data[0], rot_data[15:1]} : rot_data;
      shifts <= rot_sh ? 1 : 0;
    end else if (rot_sh) begin
      reg_q  <= {reg_q[0], reg_q[15:1]};
      shifts <= shifts + 1;
    end
  end

  typedef struct {
    logic [15:0] res;
    int          k;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  function automatic logic [15:0] rotr(input logic [15:0] d, input int k);
    logic [31:0] w;
    w = {d, d} >> k;
    return w[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Reference model: an op needs max(k,1) working cycles; LOAD always counts, ROT counts only when not held
  bit          m_busy = 1'b0, m_done = 1'b0, m_first = 1'b0;
  int          m_work = 0, m_k = 0;
  logic [15:0] m_data = '0;
  always @(posedge clk) begin
    if (rst) begin
      if (m_busy && !m_done && sb.size() > 0) void'(sb.pop_back());
      m_busy = 1'b0; m_done = 1'b0; m_first = 1'b0; m_work = 0; m_k = 0; m_data = '0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_first || !hold) m_work--;
      m_first = 1'b0;
      if (m_work == 0) m_done = 1'b1;
    end else if (start) begin
      m_busy  = 1'b1;
      m_first = 1'b1;
      m_k     = int'(amount);
      m_work  = (m_k == 0) ? 1 : m_k;
      m_data  = data_in;
      sb.push_back('{res: rotr(data_in, m_k), k: m_k});
    end
  end

  // Monitor: compare outputs mid-cycle; on done, pop the scoreboard and check the register
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_ld, exp_sh;
      exp_t e;
      exp_ld = m_busy && m_first;
      exp_sh = m_busy && !m_done && (m_first ? (m_k != 0) : !hold);
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("rot_ld", 32'(rot_ld), 32'(exp_ld));
      check("rot_sh", 32'(rot_sh), 32'(exp_sh));
      check("rot_data", 32'(rot_data), 32'(m_data));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("done_without_op", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("result", 32'(reg_q), 32'(e.res));
          check("shift_count", 32'(shifts), 32'(e.k));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'(1), 32'(0));
  endtask

  task automatic issue(input logic [15:0] d, input logic [3:0] k);
    wait_idle();
    start = 1'b1; data_in = d; amount = k;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic op(input logic [15:0] d, input logic [3:0] k);
    issue(d, k);
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; data_in = '0; amount = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    op(16'h0001, 4'd4);
    op(16'hBEEF, 4'd0);
    op(16'h0003, 4'd1);
    op(16'h8000, 4'd15);
    op(16'h0001, 4'd0);

    // Hold for two ROT cycles
    issue(16'h0001, 4'd3);
    @(posedge clk); #1;
    hold = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    hold = 1'b0;
    wait_idle();

    // Start while busy is ignored
    issue(16'h0001, 4'd3);
    start = 1'b1; data_in = 16'hFFFF; amount = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Start held across DONE: dropped in DONE, re-accepted in the following IDLE
    wait_idle();
    start = 1'b1; data_in = 16'h1234; amount = 4'd2;
    repeat (3) begin @(posedge clk); #1; end
    data_in = 16'hA5C3; amount = 4'd5;
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_idle();

    // Reset in the middle of ROT
    issue(16'hF00F, 4'd10);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op(16'h0004, 4'd2);

    // Random ops with random hold and spurious starts while busy
    repeat (150) begin
      int guard;
      issue(16'($urandom), 4'($urandom_range(0, 15)));
      guard = 0;
      while (m_busy && guard < 200) begin
        hold    = ($urandom_range(0, 3) == 0);
        start   = ($urandom_range(0, 5) == 0);
        data_in = 16'($urandom);
        amount  = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        guard++;
      end
      start = 1'b0;
      hold  = 1'b0;
      wait_idle();
    end

    repeat (3) begin @(posedge clk); #1; end
    if (sb.size() != 0) check("scoreboard_drain", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
